alu32_arbiter: RTL

Two-port request arbiter and sequencer for the shared 32-bit ALU datapath (3-bit operation select). Two requesters submit operand/opcode transactions over valid/ready handshakes. The block grants one at a time, drives registered operands and opcode into the ALU, waits a fixed settle latency and captures the result. It then returns the result to the granted requester on its own response handshake.

---
 rtl/alu32_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu32_arbiter.sv
// alu32_arbiter: two-port request arbiter and sequencer for a shared ALU.
// The block accepts one operand/opcode transaction at a time and drives it into
// the ALU through registered outputs. After ALU_LAT cycles it captures the ALU
// result and returns it to the requester that was granted.
// Optional build macro: RR_ARB_EN selects round-robin arbitration. When it is
// undefined, port 0 always wins a tie.
module alu32_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1      // legal range 1..4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // The counter counts down from ALU_LAT-1, so two bits cover the whole legal range.
    localparam logic [1:0] LAT_LOAD = 2'(ALU_LAT - 1);

    state_t            state_reg, state_next;
    logic              grant_reg;
    logic [1:0]        lat_cnt_reg;
    logic [WIDTH-1:0]  result_reg;
    logic [WIDTH-1:0]  alu_a_reg, alu_b_reg;
    logic [2:0]        alu_op_reg;

    logic              win_valid;
    logic              win_id;
    logic              accept;
    logic              rsp_hs;

    logic [1:0]        req_valid_vec;
    logic [1:0]        req_ready_vec;
    logic [1:0]        rsp_valid_vec;
    logic [1:0]        rsp_ready_vec;
    logic [WIDTH-1:0]  rsp_data_arr [2];

    assign req_valid_vec = {req1_valid, req0_valid};
    assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

    // Per-port handshake outputs. Ready is offered only in IDLE, and only to the
    // winner. Response data is zero on every port that is not being answered.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready_vec[gi] = (state_reg == IDLE) && req_valid_vec[gi] && (win_id == 1'(gi));
            assign rsp_valid_vec[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
            assign rsp_data_arr[gi]  = rsp_valid_vec[gi] ? result_reg : '0;
        end
    endgenerate

    assign req0_ready = req_ready_vec[0];
    assign req1_ready = req_ready_vec[1];
    assign rsp0_valid = rsp_valid_vec[0];
    assign rsp1_valid = rsp_valid_vec[1];
    assign rsp0_data  = rsp_data_arr[0];
    assign rsp1_data  = rsp_data_arr[1];
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_op     = alu_op_reg;
    assign busy       = (state_reg != IDLE);

    assign accept = (state_reg == IDLE) && win_valid;
    assign rsp_hs = (state_reg == RESP) && rsp_ready_vec[grant_reg];

`ifdef RR_ARB_EN
    logic last_grant_reg;

    // Arbitration pointer: remembers the last port served. It moves only when a
    // response is actually delivered, so a reset-aborted transaction does not count.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= 1'b1;
        end else if (rsp_hs) begin
            last_grant_reg <= grant_reg;
        end
    end

    // Round-robin winner: on a tie, serve the port that was not served last.
    always_comb begin
        win_valid = |req_valid_vec;
        win_id    = ~req_valid_vec[0];
        if (&req_valid_vec) begin
            win_id = ~last_grant_reg;
        end
    end
`else
    // Fixed-priority winner: port 0 wins whenever it is requesting.
    always_comb begin
        win_valid = |req_valid_vec;
        win_id    = ~req_valid_vec[0];
    end
`endif

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_valid)            state_next = EXEC;
            EXEC:    if (lat_cnt_reg == 2'd0)  state_next = RESP;
            RESP:    if (rsp_hs)               state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    // State, operand latch, settle countdown and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            grant_reg   <= 1'b0;
            lat_cnt_reg <= 2'd0;
            result_reg  <= '0;
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
            alu_op_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                alu_a_reg   <= win_id ? req1_a  : req0_a;
                alu_b_reg   <= win_id ? req1_b  : req0_b;
                alu_op_reg  <= win_id ? req1_op : req0_op;
                grant_reg   <= win_id;
                lat_cnt_reg <= LAT_LOAD;
            end
            if (state_reg == EXEC) begin
                if (lat_cnt_reg == 2'd0) begin
                    result_reg <= alu_result;
                end else begin
                    lat_cnt_reg <= lat_cnt_reg - 2'd1;
                end
            end
        end
    end

endmodule
